// File: rtl/priority_arbiter_n.sv
// ----------------------------------------------------------------------------
// priority_arbiter_n
//
// Registered N-way request arbiter. It samples N level request lines and
// selects one winner. The winner's binary index and one-hot grant are
// presented on a valid/ready output and held stable until the consumer
// accepts them. IDLE is always visited between grants, so the arbiter issues
// at most one grant every two cycles.
//
// Parameters:
//   N      number of request inputs (1..64)
//   IDX_W  index width, max(1, $clog2(N)); the parent must pass a value
//          consistent with N
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   req         level request lines; bit i = requester i
//   out_ready   consumer accepts the current grant
//   out_valid   grant present on out_idx/out_onehot
//   out_idx     binary index of the granted requester
//   out_onehot  one-hot form of out_idx; all-zero while out_valid=0
//   gnt_ack     one-cycle one-hot pulse in the cycle after acceptance
//   busy        high while a grant is outstanding
//
// Configuration:
//   PRIO_ARB_RR_EN  When defined, selection is round-robin: rr_ptr marks the
//                   highest-priority slot, and the search descends from it with
//                   wrap-around. When undefined, selection is fixed priority:
//                   the highest set index wins, and no pointer register is
//                   built. The ports are identical in both builds.
// ----------------------------------------------------------------------------
module priority_arbiter_n #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot,
    output logic [N-1:0]     gnt_ack,
    output logic             busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q;
    logic             out_valid_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [N-1:0]     out_onehot_q;
    logic [N-1:0]     gnt_ack_q;
    logic             busy_q;

    // Combinational winner for the current request vector.
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_oh;

`ifdef PRIO_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    // Search order is rr_ptr, rr_ptr-1, ..., 0, N-1, ... The loop walks from
    // the farthest slot to the nearest one, so the slot closest to rr_ptr
    // is assigned last and wins.
    always_comb begin
        int unsigned ptr;
        int unsigned dist;
        int unsigned slot;
        logic [N-1:0] sh;
        win_idx = '0;
        win_oh  = '0;
        ptr     = 32'(rr_ptr_q);
        dist    = 0;
        slot    = 0;
        sh      = '0;
        for (int unsigned k = N; k > 0; k--) begin
            dist = k - 1;
            // ptr < N always holds, so this wrap never yields slot >= N.
            slot = (ptr >= dist) ? (ptr - dist) : (ptr + N - dist);
            sh   = req >> slot;
            if (sh[0]) begin
                win_idx = IDX_W'(slot);
                win_oh  = N'(1) << slot;
            end
        end
    end

    // After an acceptance, the slot just below the winner becomes the top
    // slot. This makes the last winner the lowest-priority slot.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == StGrant && out_ready) begin
            rr_ptr_d = (out_idx_q == '0) ? IDX_W'(N - 1) : out_idx_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: ascending scan, so the highest set index is assigned
    // last and wins.
    always_comb begin
        logic [N-1:0] sh;
        win_idx = '0;
        win_oh  = '0;
        sh      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sh = req >> i;
            if (sh[0]) begin
                win_idx = IDX_W'(i);
                win_oh  = N'(1) << i;
            end
        end
    end
`endif

    // Control FSM. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            gnt_ack_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            gnt_ack_q <= '0;
            case (state_q)
                StIdle: begin
                    if (|req) begin
                        state_q      <= StGrant;
                        out_valid_q  <= 1'b1;
                        out_idx_q    <= win_idx;
                        out_onehot_q <= win_oh;
                        busy_q       <= 1'b1;
                    end
                end
                StGrant: begin
                    // The grant is frozen here; req is not looked at until
                    // the handshake completes.
                    if (out_ready) begin
                        state_q      <= StIdle;
                        out_valid_q  <= 1'b0;
                        out_onehot_q <= '0;
                        busy_q       <= 1'b0;
                        gnt_ack_q    <= out_onehot_q;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    out_valid_q  <= 1'b0;
                    out_onehot_q <= '0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_onehot = out_onehot_q;
    assign gnt_ack    = gnt_ack_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_priority_arbiter_n.sv
// ----------------------------------------------------------------------------
// tb_priority_arbiter_n
//
// Directed bench for priority_arbiter_n with N=4. It applies a table of
// {inputs, expected outputs} records, one clock per record. It then runs
// hand-written sequences for idle stretches, reset in the middle of a grant,
// and back-to-back grants under a held request. Expected values depend on
// PRIO_ARB_RR_EN only where fixed-priority and round-robin selection differ.
// ----------------------------------------------------------------------------
module tb_priority_arbiter_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_idx;
    logic [3:0] out_onehot;
    logic [3:0] gnt_ack;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    priority_arbiter_n #(
        .N     (4),
        .IDX_W (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .gnt_ack    (gnt_ack),
        .busy       (busy)
    );

    typedef struct {
        string      name;
        logic       rst_n;
        logic [3:0] req;
        logic       rdy;
        logic       e_valid;
        logic [1:0] e_idx;
        logic       chk_idx;
        logic [3:0] e_oh;
        logic [3:0] e_ack;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    // Drive the inputs, then sample 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic [3:0] q, input logic rd);
        rst_n     = r;
        req       = q;
        out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic ev, input logic [1:0] ei,
                         input logic ci, input logic [3:0] eo, input logic [3:0] ea,
                         input logic eb);
        n_vec++;
        if (out_valid !== ev) begin
            n_err++;
            $display("FAIL %s: out_valid got %0b want %0b", nm, out_valid, ev);
        end
        if (ci && out_idx !== ei) begin
            n_err++;
            $display("FAIL %s: out_idx got %0d want %0d", nm, out_idx, ei);
        end
        if (out_onehot !== eo) begin
            n_err++;
            $display("FAIL %s: out_onehot got %b want %b", nm, out_onehot, eo);
        end
        if (gnt_ack !== ea) begin
            n_err++;
            $display("FAIL %s: gnt_ack got %b want %b", nm, gnt_ack, ea);
        end
        if (busy !== eb) begin
            n_err++;
            $display("FAIL %s: busy got %0b want %0b", nm, busy, eb);
        end
    endtask

    initial begin
        logic [3:0] one;
        int         exp_seq[5];

        one       = 4'b0001;
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;

        // name, rst_n, req, rdy, valid, idx, chk_idx, onehot, ack, busy
        vecs.push_back('{"rst_a",     1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{"rst_b",     1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{"rst_c",     1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{"g_0110",    1'b1, 4'b0110, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0000, 1'b1});
        vecs.push_back('{"ack_0110",  1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0100, 1'b0});
        vecs.push_back('{"gap",       1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{"hold_g",    1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 4'b0000, 1'b1});
        for (int i = 0; i < 4; i++) begin
            vecs.push_back('{"hold_n",    1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 4'b0000, 1'b1});
        end
        vecs.push_back('{"hold_drop", 1'b1, 4'b0001, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 4'b0000, 1'b1});
        vecs.push_back('{"hold_acc",  1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b1000, 1'b0});
        vecs.push_back('{"next_0",    1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0000, 1'b1});
        vecs.push_back('{"ack_0",     1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0001, 1'b0});
        vecs.push_back('{"g_0011",    1'b1, 4'b0011, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0000, 1'b1});
        vecs.push_back('{"ack_0011",  1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0010, 1'b0});
`ifdef PRIO_ARB_RR_EN
        // rr_ptr is 0 here, so slot 0 is searched first.
        vecs.push_back('{"g_0101",    1'b1, 4'b0101, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0000, 1'b1});
        vecs.push_back('{"ack_0101",  1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0001, 1'b0});
`else
        vecs.push_back('{"g_0101",    1'b1, 4'b0101, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0000, 1'b1});
        vecs.push_back('{"ack_0101",  1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0100, 1'b0});
`endif
        vecs.push_back('{"g_1001",    1'b1, 4'b1001, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 4'b0000, 1'b1});
        vecs.push_back('{"ack_1001",  1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b1000, 1'b0});
        vecs.push_back('{"rdy_idle",  1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0});

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].req, vecs[i].rdy);
            check(vecs[i].name, vecs[i].e_valid, vecs[i].e_idx, vecs[i].chk_idx,
                  vecs[i].e_oh, vecs[i].e_ack, vecs[i].e_busy);
        end

        // Long stretch with no requests.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'b0000, i[0]);
            check("no_req", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        end

        // Reset during GRANT with idx 1: the grant is never acknowledged.
        step(1'b1, 4'b0010, 1'b0);
        check("mid_g", 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0000, 1'b1);
        step(1'b0, 4'b0010, 1'b1);
        check("mid_rst", 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b0000, 1'b1);
            check("mid_noack", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        end

        // Grant idx 0 first, so the round-robin pointer ends at 3. Then hold
        // all four requests with out_ready high.
        step(1'b1, 4'b0001, 1'b1);
        check("pre_g", 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0000, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        check("pre_ack", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0001, 1'b0);
`ifdef PRIO_ARB_RR_EN
        exp_seq = '{3, 2, 1, 0, 3};
`else
        exp_seq = '{3, 3, 3, 3, 3};
`endif
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1111, 1'b1);
            check("seq_g", 1'b1, 2'(exp_seq[i]), 1'b1, one << exp_seq[i], 4'b0000, 1'b1);
            step(1'b1, 4'b1111, 1'b1);
            check("seq_ack", 1'b0, 2'd0, 1'b0, 4'b0000, one << exp_seq[i], 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
